mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 ex_mem_op  in  4  memory op: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as none.
REQ-004 ex_mem_addr  in  32  effective byte address. ex_mem_sdata  in  32  store source.
REQ-005 ex_reg_waddr in 32, ex_reg_we in 1, ex_reg_wdata in 32, ex_csr_waddr in 32, ex_csr_we in 1, ex_csr_wdata in 32: instruction results from the EX/MEM latch.
REQ-006 stall  in  6  pipeline stall vector; bit 4 high means the MEM/WB latch holds this cycle.
REQ-007 dbus_req out 1, dbus_we out 1, dbus_addr out 32 (word aligned), dbus_be out 4, dbus_wdata out 32: data-bus request.
REQ-008 dbus_ack in 1, dbus_rdata in 32: bus completion and read word, valid together.
REQ-009 mem_reg_waddr out 32, mem_reg_we out 1, mem_reg_wdata out 32, mem_csr_waddr out 32, mem_csr_we out 1, mem_csr_wdata out 32: outputs to the MEM/WB latch.
REQ-010 stallreq_mem  out  1  requests a hold of all stages 0-3 while an access is outstanding.
REQ-011 mem_misalign  out  1  misaligned-access flag (see Configuration).

Function
REQ-012 FSM states: IDLE, WAIT, DONE. IDLE with op none: outputs pass ex_* through combinationally, stallreq_mem=0, no bus activity.
REQ-013 IDLE with a load or store: stallreq_mem=1 combinationally; next edge goes to WAIT and registers dbus_req=1 with addr, be, wdata and we.
REQ-014 WAIT: dbus_req and all dbus_* outputs stay stable until dbus_ack; stallreq_mem=1; on ack the edge captures rdata, drops dbus_req and goes to DONE.
REQ-015 DONE: stallreq_mem=0; outputs present the final result; if stall[4]=0 the next edge goes to IDLE, otherwise the FSM stays in DONE with outputs held.
REQ-016 Minimum load/store latency is 3 cycles (IDLE, WAIT with ack, DONE). Each extra ack-less WAIT cycle adds one cycle.
REQ-017 dbus_addr = {ex_mem_addr[31:2],2'b00}.
REQ-018 Store lanes: SB replicates sdata[7:0] to all bytes, be=1<<addr[1:0]. SH replicates sdata[15:0], be=4'b0011 (addr[1]=0) or 4'b1100. SW uses be=4'b1111. Loads use be=4'b1111 and dbus_we=0.
REQ-019 Load data: select the byte by addr[1:0] or the halfword by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend. The result replaces mem_reg_wdata; waddr and we pass through.
REQ-020 Stores pass ex_reg_we through unchanged; csr fields always pass through unchanged.
REQ-021 An ack arriving in IDLE or DONE is ignored.

Reset
REQ-022 Asserting rst at any time, including mid-WAIT, forces state IDLE and clears dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, the captured rdata and mem_misalign to 0 immediately, without waiting for a clock.
REQ-023 During reset, combinational pass-through still follows ex_* and stallreq_mem=0.

Configuration
REQ-024 Macro MEM_MISALIGN_EXC_EN defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, issues no bus request. mem_misalign=1 for that cycle, mem_reg_we=0, and the FSM stays in IDLE.
REQ-025 Macro undefined: mem_misalign is tied to 0; halfword accesses ignore addr[0] and word accesses ignore addr[1:0].

Verification
REQ-026 LW at 0x100, ack in the first WAIT cycle, rdata=0xDEADBEEF -> in DONE mem_reg_wdata=0xDEADBEEF; stallreq_mem high for exactly 2 cycles.
REQ-027 LB at 0x103 with rdata=0x80FFFFFF -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-028 SH at 0x102 with sdata=0x1234ABCD, 3 wait cycles -> dbus_be=1100 and dbus_wdata=0xABCDABCD, held stable 4 cycles until ack.
REQ-029 rst low during WAIT -> dbus_req=0 with no clock edge; after release a new LW completes normally.
REQ-030 DONE with stall[4]=1 for 2 cycles -> FSM stays in DONE and outputs hold; returns to IDLE on the edge after stall[4] falls.
REQ-031 MEM_MISALIGN_EXC_EN defined, LW at 0x101 -> mem_misalign=1, dbus_req stays 0, mem_reg_we=0.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: load/store stage between the EX/MEM and MEM/WB latches, driving a single-beat data bus.
// Define MEM_MISALIGN_EXC_EN to flag misaligned halfword/word accesses instead of issuing them.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_sdata,
    input  logic [31:0] ex_reg_waddr,
    input  logic        ex_reg_we,
    input  logic [31:0] ex_reg_wdata,
    input  logic [31:0] ex_csr_waddr,
    input  logic        ex_csr_we,
    input  logic [31:0] ex_csr_wdata,
    input  logic [5:0]  stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_reg_waddr,
    output logic        mem_reg_we,
    output logic [31:0] mem_reg_wdata,
    output logic [31:0] mem_csr_waddr,
    output logic        mem_csr_we,
    output logic [31:0] mem_csr_wdata,
    output logic        stallreq_mem,
    output logic        mem_misalign
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_alo;
    logic [31:0] r_rdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_issue;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_done_load;
    logic        w_unused;

    assign w_unused   = ^{stall[5], stall[3:0]};
    assign w_is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LHU);
    assign w_is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);

`ifdef MEM_MISALIGN_EXC_EN
    assign w_misalign = (((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH))
                         && ex_mem_addr[0])
                     || (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW))
                         && (ex_mem_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = (w_is_load || w_is_store) && !w_misalign;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        case (ex_mem_op)
            OP_SB: begin
                w_be    = 4'b0001 << ex_mem_addr[1:0];
                w_wdata = {4{ex_mem_sdata[7:0]}};
            end
            OP_SH: begin
                w_be    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_mem_sdata[15:0]}};
            end
            OP_SW:   w_wdata = ex_mem_sdata;
            default: ;
        endcase
    end

    // Lane extraction works on the op/offset captured at issue, so DONE is independent of ex_*.
    assign w_byte = r_rdata[{r_alo, 3'b000} +: 8];
    assign w_half = r_alo[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_load = r_rdata;
        case (r_op)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'h0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'h0, w_half};
            default: ;
        endcase
    end

    assign w_done_load = (r_state == S_DONE) && (r_op >= OP_LB) && (r_op <= OP_LHU);

    // Reset gates the combinational flags so they drop without a clock edge.
    assign mem_misalign  = rst && (r_state == S_IDLE) && w_misalign;
    assign stallreq_mem  = rst && (((r_state == S_IDLE) && w_issue) || (r_state == S_WAIT));
    assign mem_reg_waddr = ex_reg_waddr;
    assign mem_reg_we    = ex_reg_we && !mem_misalign;
    assign mem_reg_wdata = w_done_load ? w_load : ex_reg_wdata;
    assign mem_csr_waddr = ex_csr_waddr;
    assign mem_csr_we    = ex_csr_we;
    assign mem_csr_wdata = ex_csr_wdata;

    // NOTE: sequential state uses non-blocking assignments only; all registers, including
    // the captured read word, are cleared asynchronously so a mid-access reset leaves no residue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= 4'd0;
            r_alo      <= 2'b00;
            r_rdata    <= 32'h0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0;
            dbus_be    <= 4'b0000;
            dbus_wdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state    <= S_WAIT;
                        r_op       <= ex_mem_op;
                        r_alo      <= ex_mem_addr[1:0];
                        dbus_req   <= 1'b1;
                        dbus_we    <= w_is_store;
                        dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
                        dbus_be    <= w_be;
                        dbus_wdata <= w_wdata;
                    end
                end
                S_WAIT: begin
                    if (dbus_ack) begin
                        r_state  <= S_DONE;
                        r_rdata  <= dbus_rdata;
                        dbus_req <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!stall[4]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized load/store traffic against a transaction-level timeline model,
// plus directed scenarios pinning load extension, store lanes, stall holding and reset.
module tb_mem_access;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ex_mem_op = 4'd0;
    logic [31:0] ex_mem_addr = 32'h0, ex_mem_sdata = 32'h0;
    logic [31:0] ex_reg_waddr = 32'h0, ex_reg_wdata = 32'h0;
    logic        ex_reg_we = 1'b0;
    logic [31:0] ex_csr_waddr = 32'h0, ex_csr_wdata = 32'h0;
    logic        ex_csr_we = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] mem_reg_waddr, mem_reg_wdata, mem_csr_waddr, mem_csr_wdata;
    logic        mem_reg_we, mem_csr_we, stallreq_mem, mem_misalign;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
        .ex_reg_waddr(ex_reg_waddr), .ex_reg_we(ex_reg_we), .ex_reg_wdata(ex_reg_wdata),
        .ex_csr_waddr(ex_csr_waddr), .ex_csr_we(ex_csr_we), .ex_csr_wdata(ex_csr_wdata),
        .stall(stall),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_reg_waddr(mem_reg_waddr), .mem_reg_we(mem_reg_we), .mem_reg_wdata(mem_reg_wdata),
        .mem_csr_waddr(mem_csr_waddr), .mem_csr_we(mem_csr_we), .mem_csr_wdata(mem_csr_wdata),
        .stallreq_mem(stallreq_mem), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected outputs for the current cycle, set by the stimulus timeline.
    logic        chk_en = 1'b0;
    logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0, e_mis = 1'b0, e_rwe = 1'b0;
    logic        chk_rd = 1'b0, in_done = 1'b0;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_rwdata = 32'h0;
    logic [3:0]  e_be = 4'h0;

    int          n_stall = 0, n_req = 0, n_mis = 0;
    logic [3:0]  last_be = 4'h0;
    logic [31:0] last_wd = 32'h0, last_rd = 32'h0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stallreq_mem", 32'(stallreq_mem), 32'(e_stall));
            check("dbus_req", 32'(dbus_req), 32'(e_req));
            check("mem_misalign", 32'(mem_misalign), 32'(e_mis));
            check("mem_reg_we", 32'(mem_reg_we), 32'(e_rwe));
            check("mem_reg_waddr", mem_reg_waddr, ex_reg_waddr);
            check("mem_csr_waddr", mem_csr_waddr, ex_csr_waddr);
            check("mem_csr_we", 32'(mem_csr_we), 32'(ex_csr_we));
            check("mem_csr_wdata", mem_csr_wdata, ex_csr_wdata);
            if (chk_rd) check("mem_reg_wdata", mem_reg_wdata, e_rwdata);
            if (e_req) begin
                check("dbus_we", 32'(dbus_we), 32'(e_we));
                check("dbus_addr", dbus_addr, e_addr);
                check("dbus_be", 32'(dbus_be), 32'(e_be));
                if (e_we) check("dbus_wdata", dbus_wdata, e_wdata);
            end
            if (stallreq_mem) n_stall++;
            if (mem_misalign) n_mis++;
            if (dbus_req) begin
                n_req++;
                last_be = dbus_be;
                last_wd = dbus_wdata;
            end
            if (in_done) last_rd = mem_reg_wdata;
        end
    end

    function automatic logic misaligned(input logic [3:0] op, input logic [31:0] addr);
`ifdef MEM_MISALIGN_EXC_EN
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return addr[0];
        if (op == OP_LW || op == OP_SW) return addr[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [3:0] op, input logic [1:0] alo,
                                             input logic [31:0] rd);
        logic [31:0] v;
        case (op)
            OP_LB, OP_LBU: begin
                v = (rd >> (8 * alo)) & 32'hFF;
                if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            OP_LH, OP_LHU: begin
                v = (rd >> (alo[1] ? 16 : 0)) & 32'hFFFF;
                if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: IDLE cycle, then (if issued) nwait ack-less WAIT cycles, the ack cycle,
    // and 1+nstall DONE cycles with stall[4] held for the first nstall of them.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input int nwait, input logic [31:0] rdata, input int nstall);
        logic is_ld, is_st, mis, iss;
        is_ld = (op >= OP_LB) && (op <= OP_LHU);
        is_st = (op >= OP_SB) && (op <= OP_SW);
        mis   = (is_ld || is_st) && misaligned(op, addr);
        iss   = (is_ld || is_st) && !mis;

        ex_mem_op = op; ex_mem_addr = addr; ex_mem_sdata = sdata;
        ex_reg_waddr = $urandom; ex_reg_we = 1'($urandom); ex_reg_wdata = $urandom;
        ex_csr_waddr = $urandom; ex_csr_we = 1'($urandom); ex_csr_wdata = $urandom;
        stall = 6'($urandom);
        dbus_ack = 1'($urandom); dbus_rdata = $urandom;
        e_stall = iss; e_req = 1'b0; e_mis = mis; e_rwe = ex_reg_we & ~mis;
        chk_rd = 1'b1; e_rwdata = ex_reg_wdata;
        tick();
        if (!iss) return;

        e_req = 1'b1; e_we = is_st; e_addr = addr & 32'hFFFF_FFFC; e_mis = 1'b0;
        e_rwe = ex_reg_we; chk_rd = 1'b0; e_stall = 1'b1;
        case (op)
            OP_SB:   begin e_be = 4'b0001 << addr[1:0];          e_wdata = 32'(sdata[7:0]) * 32'h01010101; end
            OP_SH:   begin e_be = addr[1] ? 4'b1100 : 4'b0011;   e_wdata = 32'(sdata[15:0]) * 32'h00010001; end
            OP_SW:   begin e_be = 4'b1111;                       e_wdata = sdata; end
            default: begin e_be = 4'b1111;                       e_wdata = 32'h0; end
        endcase
        for (int k = 0; k <= nwait; k++) begin
            dbus_ack = (k == nwait);
            dbus_rdata = (k == nwait) ? rdata : $urandom;
            tick();
        end

        e_req = 1'b0; e_stall = 1'b0; chk_rd = 1'b1; in_done = 1'b1;
        e_rwdata = is_ld ? load_val(op, addr[1:0], rdata) : ex_reg_wdata;
        for (int s = 0; s <= nstall; s++) begin
            stall = 6'($urandom);
            stall[4] = (s < nstall);
            dbus_ack = 1'($urandom); dbus_rdata = $urandom;
            tick();
        end
        in_done = 1'b0;
    endtask

    initial begin
        int s0;
        ex_mem_op = OP_LW; ex_mem_addr = 32'h104; ex_reg_wdata = 32'h13572468; ex_reg_we = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_dbus_req", 32'(dbus_req), 32'd0);
        check("rst_dbus_we", 32'(dbus_we), 32'd0);
        check("rst_dbus_be", 32'(dbus_be), 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_wdata", dbus_wdata, 32'd0);
        check("rst_stallreq", 32'(stallreq_mem), 32'd0);
        check("rst_misalign", 32'(mem_misalign), 32'd0);
        check("rst_passthru", mem_reg_wdata, 32'h13572468);
        #9 ex_mem_op = OP_NONE;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;

        s0 = n_stall;
        access(OP_LW, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
        check("lw_stall_cycles", 32'(n_stall - s0), 32'd2);
        check("lw_data", last_rd, 32'hDEADBEEF);

        access(OP_LB, 32'h103, 32'h0, 1, 32'h80FFFFFF, 0);
        check("lb_data", last_rd, 32'hFFFFFF80);
        access(OP_LBU, 32'h103, 32'h0, 0, 32'h80FFFFFF, 0);
        check("lbu_data", last_rd, 32'h00000080);

        s0 = n_req;
        access(OP_SH, 32'h102, 32'h1234ABCD, 3, 32'h0, 0);
        check("sh_hold_cycles", 32'(n_req - s0), 32'd4);
        check("sh_be", 32'(last_be), 32'hC);
        check("sh_wdata", last_wd, 32'hABCDABCD);

        access(OP_LHU, 32'h202, 32'h0, 0, 32'h8001F00F, 2);
        check("lhu_stall_hold", last_rd, 32'h00008001);
        access(OP_LW, 32'h300, 32'h0, 0, 32'h0BADF00D, 0);
        check("lw_after_stall", last_rd, 32'h0BADF00D);

        chk_en = 1'b0;
        ex_mem_op = OP_LW; ex_mem_addr = 32'h200; ex_reg_wdata = 32'h55AA55AA;
        dbus_ack = 1'b0; stall = 6'd0;
        tick();
        #2 check("wait_req_before_rst", 32'(dbus_req), 32'd1);
        rst = 1'b0;
        #1;
        check("midwait_rst_req", 32'(dbus_req), 32'd0);
        check("midwait_rst_stallreq", 32'(stallreq_mem), 32'd0);
        check("midwait_rst_passthru", mem_reg_wdata, 32'h55AA55AA);
        ex_mem_op = OP_NONE;
        #2 rst = 1'b1;
        tick();
        chk_en = 1'b1;
        access(OP_LW, 32'h204, 32'h0, 1, 32'hCAFEF00D, 0);
        check("lw_after_rst", last_rd, 32'hCAFEF00D);

`ifdef MEM_MISALIGN_EXC_EN
        s0 = n_req;
        begin
            int m0;
            m0 = n_mis;
            access(OP_LW, 32'h101, 32'h0, 0, 32'h0, 0);
            check("misalign_no_req", 32'(n_req - s0), 32'd0);
            check("misalign_seen", 32'(n_mis - m0), 32'd1);
        end
`endif

        for (int t = 0; t < 200; t++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            access(op, $urandom, $urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) access(OP_NONE, $urandom, $urandom, 0, 32'h0, 0);
        end

        chk_en = 1'b0;
        #2;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
